l2_ram_bank_array_ctrl: RTL and testbench
=========================================

// Module: l2_ram_bank_array_ctrl
// PURPOSE
//  Parametrised L2 interleaved bank array for the SoC memory subsystem: NB_BANKS
//  independent 32-bit single-port banks, each of BANK_WORDS words (BANK_WORDS need
//  not be a power of two). Adds per-bank req/gnt/rvalid handshake, address range
//  checking and a hardware init FSM that zero-fills all banks. Sits behind the L2
//  interconnect, one port per bank.
// PARAMETERS
//  NB_BANKS       4      number of interleaved banks (1..16)
//  BANK_WORDS     29184  words per bank
//  ADDR_WIDTH     15     word address width per bank; 2**ADDR_WIDTH >= BANK_WORDS
//  INIT_ON_RESET  1      1: zero-fill starts automatically on reset release
// PORTS
//  clk_i         in   1                  clock
//  rst_i         in   1                  reset, asynchronous, active-high
//  req_i         in   NB_BANKS           per-bank request
//  gnt_o         out  NB_BANKS           per-bank grant (same cycle as req_i)
//  we_i          in   NB_BANKS           1 = write, 0 = read
//  add_i         in   NB_BANKS*ADDR_WIDTH per-bank word address
//  wdata_i       in   NB_BANKS*32        write data
//  be_i          in   NB_BANKS*4         byte enables, active-high
//  rvalid_o      out  NB_BANKS           response valid (reads and writes)
//  rdata_o       out  NB_BANKS*32        read data, valid with rvalid_o
//  rerr_o        out  NB_BANKS           out-of-range access, valid with rvalid_o
//  init_start_i  in   1                  pulse: start zero-fill
//  init_busy_o   out  1                  zero-fill in progress
//  init_done_o   out  1                  sticky: at least one fill completed
// BEHAVIOUR
//  - Reset: gnt_o=0, rvalid_o=0, rdata_o=0, rerr_o=0, init_done_o=0;
//    init_busy_o=INIT_ON_RESET. FSM -> INIT if INIT_ON_RESET else READY.
//  - FSM states: READY, INIT. READY->INIT on init_start_i. INIT->READY after the
//    cycle writing address BANK_WORDS-1; init_done_o set on that transition.
//  - INIT: counter 0..BANK_WORDS-1, one zero word per cycle written to all banks
//    in parallel, full byte enables; fill takes exactly BANK_WORDS cycles;
//    gnt_o=0; init_start_i ignored. Reset mid-init aborts; memory content is
//    undefined and the fill restarts per INIT_ON_RESET.
//  - READY: gnt_o[b]=req_i[b] (combinational, no bank conflicts, banks
//    independent). A granted access is performed at the clock edge.
//  - Latency: rvalid_o[b] one cycle after grant; rvalid_o asserts for writes too.
//  - Writes merge per byte: only bytes with be_i[k]=1 updated; be_i=0 writes nothing.
//  - add_i >= BANK_WORDS: granted; write dropped; read returns 32'hBADCAB1E;
//    rerr_o=1 with rvalid_o. In-range: rerr_o=0.
//  - Read data of a non-responding bank holds its last value; rdata_o is
//    defined only while rvalid_o=1.
//  - Back-to-back accesses on a bank: one per cycle, full throughput.
//  - init_start_i in the same cycle as req_i: start wins; that request is not
//    granted; INIT begins next cycle.
// CONFIGURATION
//  L2_RDATA_REG_EN: when defined, output register on rvalid_o/rdata_o/rerr_o;
//  read latency 2 cycles, throughput unchanged, registers reset to 0.
//  When not defined: latency 1 cycle, as above.
// STRUCTURE
//  - Package l2_ram_pkg: typedef state_e {READY, INIT}; constant
//    L2_OOR_PATTERN=32'hBADCAB1E; typedef word_t logic[31:0]; be_t logic[3:0].
//  - Sub-module l2_ram_bank_model (behavioural BANK_WORDS x 32 single-port array,
//    byte-enabled, 1-cycle read), instantiated NB_BANKS times in a generate loop;
//    init FSM and counter shared in the top.
// TESTING
//  1 Reset with INIT_ON_RESET=1, BANK_WORDS=64 -> init_busy_o=1 for 64 cycles,
//    gnt_o=0 throughout, then init_done_o=1; reads of bank 2 addr 63 return 0.
//  2 Write bank 0 addr 5 data 32'h11223344 be=4'hF, then be=4'b0010 data
//    32'hAABBCCDD -> read returns 32'h1122CC44, rvalid_o 1 cycle after gnt
//    (2 with L2_RDATA_REG_EN).
//  3 All 4 banks write and read every cycle for 100 cycles -> gnt_o=4'hF every
//    cycle, no stalls, data per bank matches scoreboard.
//  4 Read bank 1 addr BANK_WORDS (out of range) -> rdata_o=32'hBADCAB1E,
//    rerr_o=1; prior write to same address left memory unchanged.
//  5 init_start_i with simultaneous req_i=4'hF -> gnt_o=0; previously written
//    data reads 0 after fill completes.
//  6 Assert rst_i at fill counter 20 -> all outputs at reset values immediately;
//    fill restarts at 0 after release and runs full BANK_WORDS cycles.

Source files
------------

// File: rtl/l2_ram_pkg.sv
// Shared types and constants for the L2 interleaved bank array.
package l2_ram_pkg;

  typedef enum logic {
    READY = 1'b0,
    INIT  = 1'b1
  } state_e;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  // Returned on reads that fall outside the populated part of a bank
  localparam word_t L2_OOR_PATTERN = 32'hBADCAB1E;

endpackage

// File: rtl/l2_ram_bank_array_ctrl_if.sv
// Per-bank request/response bus of the L2 bank array plus the zero-fill control.
interface l2_ram_bank_array_ctrl_if #(
  parameter int NB_BANKS   = 4,
  parameter int ADDR_WIDTH = 15
);

  logic [NB_BANKS-1:0]            req_i;
  logic [NB_BANKS-1:0]            gnt_o;
  logic [NB_BANKS-1:0]            we_i;
  logic [NB_BANKS*ADDR_WIDTH-1:0] add_i;
  logic [NB_BANKS*32-1:0]         wdata_i;
  logic [NB_BANKS*4-1:0]          be_i;
  logic [NB_BANKS-1:0]            rvalid_o;
  logic [NB_BANKS*32-1:0]         rdata_o;
  logic [NB_BANKS-1:0]            rerr_o;
  logic                           init_start_i;
  logic                           init_busy_o;
  logic                           init_done_o;

  modport master (
    output req_i, we_i, add_i, wdata_i, be_i, init_start_i,
    input  gnt_o, rvalid_o, rdata_o, rerr_o, init_busy_o, init_done_o
  );

  modport slave (
    input  req_i, we_i, add_i, wdata_i, be_i, init_start_i,
    output gnt_o, rvalid_o, rdata_o, rerr_o, init_busy_o, init_done_o
  );

endinterface

// File: rtl/l2_ram_bank_model.sv
// Behavioural single-port bank: WORDS x 32, byte-enabled writes, 1-cycle read.
// The read register only loads on reads, so it holds its value across writes.
module l2_ram_bank_model
  import l2_ram_pkg::*;
#(
  parameter int WORDS = 29184,
  parameter int IDX_W = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  word_t            wdata,
  input  be_t              be,
  output word_t            rdata
);

  word_t mem [WORDS];

  // Byte-merged write into the array
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/l2_ram_bank_array_ctrl.sv
// L2 interleaved bank array: NB_BANKS independent banks with per-bank
// req/gnt/rvalid handshake, range checking and a shared zero-fill FSM.
// Optional macro L2_RDATA_REG_EN adds an output register stage on
// rvalid_o/rdata_o/rerr_o (read latency 2 instead of 1).
module l2_ram_bank_array_ctrl
  import l2_ram_pkg::*;
#(
  parameter int NB_BANKS      = 4,
  parameter int BANK_WORDS    = 29184,
  parameter int ADDR_WIDTH    = 15,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  l2_ram_bank_array_ctrl_if.slave  bus
);

  localparam int IDX_W = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(BANK_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH + 1)'(BANK_WORDS);

  state_e                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    busy;
  logic                    done;
  logic [NB_BANKS-1:0]     gnt;
  logic [NB_BANKS-1:0]     oor;
  word_t                   bank_rdata [NB_BANKS];

  // Init FSM: zero-fill counter shared by all banks, registered status flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= (INIT_ON_RESET != 0) ? INIT : READY;
      cnt   <= '0;
      busy  <= (INIT_ON_RESET != 0);
      done  <= 1'b0;
    end else begin
      case (state)
        READY: begin
          if (bus.init_start_i) begin
            state <= INIT;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        INIT: begin
          if (cnt == LAST) begin
            state <= READY;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= READY;
      endcase
    end
  end

  assign bus.init_busy_o = busy;
  assign bus.init_done_o = done;

  // Grant is a pass-through of the request while idle; a fill start takes priority
  always_comb begin
    gnt = '0;
    if (state == READY && !bus.init_start_i) gnt = bus.req_i;
  end

  assign bus.gnt_o = gnt;

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    logic [ADDR_WIDTH-1:0] add_b;
    logic                  en;
    logic                  we;
    logic [IDX_W-1:0]      addr;
    word_t                 wdata;
    be_t                   be;

    assign add_b  = bus.add_i[b*ADDR_WIDTH +: ADDR_WIDTH];
    assign oor[b] = {1'b0, add_b} >= LIMIT;

    // Bank port mux: fill counter during INIT, otherwise the granted in-range access
    always_comb begin
      en    = gnt[b] & ~oor[b];
      we    = bus.we_i[b];
      addr  = add_b[IDX_W-1:0];
      wdata = bus.wdata_i[b*32 +: 32];
      be    = bus.be_i[b*4 +: 4];
      if (state == INIT) begin
        en    = 1'b1;
        we    = 1'b1;
        addr  = cnt[IDX_W-1:0];
        wdata = '0;
        be    = '1;
      end
    end

    l2_ram_bank_model #(
      .WORDS (BANK_WORDS),
      .IDX_W (IDX_W)
    ) u_bank (
      .clk   (clk_i),
      .rst   (rst_i),
      .en    (en),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .be    (be),
      .rdata (bank_rdata[b])
    );
  end

  // ---- stage p1: response one cycle after grant ----
  logic [NB_BANKS-1:0]    rvalid_p1;
  logic [NB_BANKS-1:0]    rerr_p1;
  logic [NB_BANKS-1:0]    rsel_p1;
  logic [NB_BANKS*32-1:0] rdata_p1;

  // Response flags; the pattern select only follows reads so rdata holds otherwise
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_p1 <= '0;
      rerr_p1   <= '0;
      rsel_p1   <= '0;
    end else begin
      rvalid_p1 <= gnt;
      rerr_p1   <= gnt & oor;
      for (int b = 0; b < NB_BANKS; b++) begin
        if (gnt[b] && !bus.we_i[b]) rsel_p1[b] <= oor[b];
      end
    end
  end

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_rdata
    assign rdata_p1[b*32 +: 32] = rsel_p1[b] ? L2_OOR_PATTERN : bank_rdata[b];
  end

`ifdef L2_RDATA_REG_EN
  // ---- stage p2: optional output register ----
  logic [NB_BANKS-1:0]    rvalid_p2;
  logic [NB_BANKS-1:0]    rerr_p2;
  logic [NB_BANKS*32-1:0] rdata_p2;

  // Output register stage, one extra cycle of latency at full throughput
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_p2 <= '0;
      rerr_p2   <= '0;
      rdata_p2  <= '0;
    end else begin
      rvalid_p2 <= rvalid_p1;
      rerr_p2   <= rerr_p1;
      rdata_p2  <= rdata_p1;
    end
  end

  assign bus.rvalid_o = rvalid_p2;
  assign bus.rerr_o   = rerr_p2;
  assign bus.rdata_o  = rdata_p2;
`else
  assign bus.rvalid_o = rvalid_p1;
  assign bus.rerr_o   = rerr_p1;
  assign bus.rdata_o  = rdata_p1;
`endif

endmodule

// File: tb/tb_l2_ram_bank_array_ctrl.sv
// Scoreboard bench for l2_ram_bank_array_ctrl (4 banks x 64 words).
module tb_l2_ram_bank_array_ctrl;

  localparam int NB  = 4;
  localparam int BW  = 64;
  localparam int AW  = 7;
`ifdef L2_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  exp_t        sbq [NB][$];
  exp_t        e;
  logic [31:0] model [NB][BW];

  logic [NB-1:0]   d_req   = '0;
  logic [NB-1:0]   d_we    = '0;
  logic            d_start = 1'b0;
  logic [AW-1:0]   d_add [NB];
  logic [31:0]     d_wd  [NB];
  logic [3:0]      d_be  [NB];

  l2_ram_bank_array_ctrl_if #(.NB_BANKS(NB), .ADDR_WIDTH(AW)) bus ();

  l2_ram_bank_array_ctrl #(
    .NB_BANKS      (NB),
    .BANK_WORDS    (BW),
    .ADDR_WIDTH    (AW),
    .INIT_ON_RESET (1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Monitor: pop the expected response whenever a bank presents rvalid
  always @(negedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bus.rvalid_o[b] === 1'b1) begin
        if (sbq[b].size() == 0) begin
          chk($sformatf("rvalid_unexpected_b%0d", b), 32'd1, 32'd0);
        end else begin
          e = sbq[b].pop_front();
          chk($sformatf("latency_b%0d", b), cyc, e.cyc + LAT);
          chk($sformatf("rerr_b%0d", b), {31'd0, bus.rerr_o[b]}, {31'd0, e.err});
          if (e.rd) chk($sformatf("rdata_b%0d", b), bus.rdata_o[b*32 +: 32], e.data);
        end
      end else if (sbq[b].size() > 0 && cyc > sbq[b][0].cyc + LAT) begin
        e = sbq[b].pop_front();
        chk($sformatf("rvalid_missing_b%0d", b), 32'd0, 32'd1);
      end
    end
  end

  // Drive one cycle of stimulus, check grant, push expected responses
  task automatic step(input logic [NB-1:0] exp_gnt);
    @(negedge clk);
    bus.req_i        = d_req;
    bus.we_i         = d_we;
    bus.init_start_i = d_start;
    for (int b = 0; b < NB; b++) begin
      bus.add_i[b*AW +: AW]  = d_add[b];
      bus.wdata_i[b*32 +: 32] = d_wd[b];
      bus.be_i[b*4 +: 4]     = d_be[b];
    end
    #1;
    chk("gnt", {28'd0, bus.gnt_o}, {28'd0, exp_gnt});
    for (int b = 0; b < NB; b++) begin
      if (exp_gnt[b]) begin
        exp_t x;
        x.cyc  = cyc;
        x.rd   = !d_we[b];
        x.err  = (d_add[b] >= AW'(BW));
        x.data = x.err ? 32'hBADCAB1E : model[b][d_add[b][5:0]];
        if (d_we[b] && !x.err) begin
          for (int k = 0; k < 4; k++)
            if (d_be[b][k]) model[b][d_add[b][5:0]][8*k +: 8] = d_wd[b][8*k +: 8];
        end
        sbq[b].push_back(x);
      end
    end
  endtask

  task automatic idle(input int n);
    d_req = '0;
    d_start = 1'b0;
    for (int i = 0; i < n; i++) step('0);
  endtask

  task automatic clear_model();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < BW; a++) model[b][a] = '0;
  endtask

  // Count busy cycles of a fill while requesting on all banks (none may be granted)
  task automatic wait_fill(input string name);
    int n = 0;
    bus.req_i = '1;
    for (int i = 0; i < 200; i++) begin
      if (bus.init_busy_o !== 1'b1) break;
      n++;
      chk({name, "_gnt"}, {28'd0, bus.gnt_o}, 32'd0);
      @(negedge clk);
      #1;
    end
    bus.req_i = '0;
    chk({name, "_len"}, n, BW);
    chk({name, "_done"}, {31'd0, bus.init_done_o}, 32'd1);
  endtask

  task automatic set_op(input int b, input logic we, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    d_req[b] = 1'b1;
    d_we[b]  = we;
    d_add[b] = a;
    d_wd[b]  = wd;
    d_be[b]  = be;
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      d_add[b] = '0; d_wd[b] = '0; d_be[b] = '0;
    end
    bus.req_i = '1; bus.we_i = '0; bus.add_i = '0; bus.wdata_i = '0;
    bus.be_i = '0; bus.init_start_i = 1'b0;

    // 1: reset values and automatic fill
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt",    {28'd0, bus.gnt_o},    32'd0);
    chk("rst_rvalid", {28'd0, bus.rvalid_o}, 32'd0);
    chk("rst_rdata",  bus.rdata_o[31:0] | bus.rdata_o[63:32] | bus.rdata_o[95:64] | bus.rdata_o[127:96], 32'd0);
    chk("rst_rerr",   {28'd0, bus.rerr_o},   32'd0);
    chk("rst_done",   {31'd0, bus.init_done_o}, 32'd0);
    chk("rst_busy",   {31'd0, bus.init_busy_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    wait_fill("fill1");
    clear_model();
    d_req = '0; set_op(2, 1'b0, 7'd63, 32'h0, 4'h0);
    step(4'b0100);
    idle(2);

    // 2: byte-merged writes on bank 0 addr 5
    d_req = '0; set_op(0, 1'b1, 7'd5, 32'h11223344, 4'hF); step(4'b0001);
    d_req = '0; set_op(0, 1'b1, 7'd5, 32'hAABBCCDD, 4'b0010); step(4'b0001);
    d_req = '0; set_op(0, 1'b0, 7'd5, 32'h0, 4'h0); step(4'b0001);
    d_req = '0; set_op(0, 1'b1, 7'd5, 32'hFFFFFFFF, 4'h0); step(4'b0001);
    d_req = '0; set_op(0, 1'b0, 7'd5, 32'h0, 4'h0); step(4'b0001);
    idle(3);

    // 3: all banks busy every cycle
    for (int i = 0; i < 100; i++) begin
      for (int b = 0; b < NB; b++)
        set_op(b, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      step(4'hF);
    end
    idle(3);

    // 4: out-of-range accesses on bank 1
    d_req = '0; set_op(1, 1'b1, 7'd0,  32'hCAFEF00D, 4'hF); step(4'b0010);
    d_req = '0; set_op(1, 1'b1, 7'd64, 32'h12345678, 4'hF); step(4'b0010);
    d_req = '0; set_op(1, 1'b0, 7'd64, 32'h0, 4'h0);        step(4'b0010);
    d_req = '0; set_op(1, 1'b0, 7'd0,  32'h0, 4'h0);        step(4'b0010);
    d_req = '0; set_op(3, 1'b0, 7'd127, 32'h0, 4'h0);       step(4'b1000);
    idle(3);

    // 5: fill start collides with requests on all banks
    for (int b = 0; b < NB; b++) set_op(b, 1'b1, 7'd10, 32'h5A5A0000 + b, 4'hF);
    step(4'hF);
    for (int b = 0; b < NB; b++) set_op(b, 1'b1, 7'd11, 32'hDEAD0000 + b, 4'hF);
    d_start = 1'b1;
    step(4'h0);
    d_start = 1'b0;
    d_req = '0;
    @(negedge clk);
    bus.init_start_i = 1'b0;
    #1;
    wait_fill("fill2");
    clear_model();
    d_req = '0;
    for (int b = 0; b < NB; b++) set_op(b, 1'b0, 7'd10, 32'h0, 4'h0);
    step(4'hF);
    for (int b = 0; b < NB; b++) set_op(b, 1'b0, 7'd11, 32'h0, 4'h0);
    step(4'hF);
    idle(3);

    // 6: reset in the middle of a fill
    d_req = '0; set_op(0, 1'b1, 7'd5, 32'h77777777, 4'hF); step(4'b0001);
    idle(3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_i = '1;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_gnt",    {28'd0, bus.gnt_o},    32'd0);
    chk("mid_rvalid", {28'd0, bus.rvalid_o}, 32'd0);
    chk("mid_rerr",   {28'd0, bus.rerr_o},   32'd0);
    chk("mid_rdata",  bus.rdata_o[31:0], 32'd0);
    chk("mid_done",   {31'd0, bus.init_done_o}, 32'd0);
    chk("mid_busy",   {31'd0, bus.init_busy_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    wait_fill("fill3");
    clear_model();
    d_req = '0; set_op(0, 1'b0, 7'd5, 32'h0, 4'h0);  step(4'b0001);
    d_req = '0; set_op(2, 1'b0, 7'd63, 32'h0, 4'h0); step(4'b0100);
    idle(5);

    for (int b = 0; b < NB; b++) chk($sformatf("sb_empty_b%0d", b), sbq[b].size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
